// File: rtl/bitty_fetch_ctrl_pkg.sv
// rtl/bitty_fetch_ctrl_pkg.sv - shared types and constants for the bitty fetch sequencer
package bitty_fetch_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT,
      ST_BRANCH,
      ST_UPDATE,
      ST_ERR
   } state_e;

   localparam logic [1:0] OPC_BRANCH = 2'b10;

   localparam logic [1:0] COND_EQ = 2'b00;
   localparam logic [1:0] COND_GT = 2'b01;
   localparam logic [1:0] COND_LT = 2'b10;

   // The core reports compare outcomes as small integers in d_out.
   function automatic logic cond_taken(input logic [1:0] cond, input logic [15:0] result);
      logic taken;
      case (cond)
         COND_EQ: taken = (result == 16'd0);
         COND_GT: taken = (result == 16'd1);
         COND_LT: taken = (result == 16'd2);
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/bitty_branch_eval.sv
// rtl/bitty_branch_eval.sv - branch decode and next-pc selection for the fetch sequencer
module bitty_branch_eval
   import bitty_fetch_ctrl_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic [15:0]     instr_i,
   input  logic [15:0]     core_result_i,
   input  logic [PC_W-1:0] pc_i,
   output logic            is_branch_o,
   output logic [PC_W-1:0] next_pc_o
);

   logic taken;

   assign is_branch_o = (instr_i[1:0] == OPC_BRANCH);
   assign taken       = is_branch_o && cond_taken(instr_i[3:2], core_result_i);
   assign next_pc_o   = taken ? PC_W'(instr_i[15:4]) : pc_i + PC_W'(1);

endmodule

// File: rtl/bitty_fetch_ctrl.sv
// rtl/bitty_fetch_ctrl.sv - bitty instruction sequencer: fetch, issue, wait, local branch resolve
module bitty_fetch_ctrl
   import bitty_fetch_ctrl_pkg::*;
#(
   parameter int PC_W     = 8,
   parameter int WDOG_CYC = 255
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            stop_i,
   output logic [PC_W-1:0] imem_addr_o,
   output logic            imem_rd_o,
   input  logic [15:0]     imem_data_i,
   input  logic            imem_valid_i,
   output logic [15:0]     core_instr_o,
   output logic            core_run_o,
   input  logic            core_done_i,
   input  logic [15:0]     core_result_i,
   output logic [PC_W-1:0] pc_o,
   output logic            busy_o,
   output logic            err_o
);

   localparam int              WD_W     = $clog2(WDOG_CYC + 1);
   localparam logic [WD_W-1:0] WDOG_MAX = WD_W'(WDOG_CYC);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     instr_q, instr_d;
   logic [15:0]     core_instr_q, core_instr_d;
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            imem_rd_q, core_run_q, busy_q, err_q;
   logic            is_branch;
   logic [PC_W-1:0] branch_pc;

   // Evaluated on instr_d so the FETCH decision sees the word arriving this cycle.
   bitty_branch_eval #(
      .PC_W(PC_W)
   ) u_branch_eval (
      .instr_i      (instr_d),
      .core_result_i(core_result_i),
      .pc_i         (pc_q),
      .is_branch_o  (is_branch),
      .next_pc_o    (branch_pc)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      wdog_d  = wdog_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_FETCH;
               pc_d    = '0;
            end
         end
         ST_FETCH: begin
            if (imem_valid_i) begin
               instr_d = imem_data_i;
               state_d = is_branch ? ST_BRANCH : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            wdog_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            wdog_d = wdog_q + WD_W'(1);
            if (core_done_i) begin
               state_d = ST_UPDATE;
            end else if (wdog_d == WDOG_MAX) begin
               state_d = ST_ERR;
            end
         end
         ST_BRANCH: begin
            pc_d    = branch_pc;
            state_d = stop_i ? ST_IDLE : ST_FETCH;
         end
         ST_UPDATE: begin
            pc_d    = pc_q + PC_W'(1);
            state_d = stop_i ? ST_IDLE : ST_FETCH;
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      core_instr_d = (state_d == ST_ISSUE) ? instr_d : core_instr_q;
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         pc_q         <= '0;
         instr_q      <= '0;
         core_instr_q <= '0;
         wdog_q       <= '0;
         imem_rd_q    <= 1'b0;
         core_run_q   <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         core_instr_q <= core_instr_d;
         wdog_q       <= wdog_d;
         imem_rd_q    <= (state_d == ST_FETCH);
         core_run_q   <= (state_d == ST_ISSUE);
         busy_q       <= (state_d != ST_IDLE) && (state_d != ST_ERR);
         err_q        <= (state_d == ST_ERR);
      end
   end

   assign imem_addr_o  = pc_q;
   assign pc_o         = pc_q;
   assign imem_rd_o    = imem_rd_q;
   assign core_instr_o = core_instr_q;
   assign core_run_o   = core_run_q;
   assign busy_o       = busy_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_bitty_fetch_ctrl.sv
// tb/tb_bitty_fetch_ctrl.sv - self-checking bench for bitty_fetch_ctrl
module tb_bitty_fetch_ctrl;

   localparam int PC_W = 8;
   localparam int WDOG = 255;

   logic            clk = 1'b0;
   logic            rst_ni = 1'b0;
   logic            start = 1'b0;
   logic            stop = 1'b0;
   logic [PC_W-1:0] imem_addr_o;
   logic            imem_rd_o;
   logic [15:0]     imem_data = 16'hBEEF;
   logic            imem_valid = 1'b0;
   logic [15:0]     core_instr_o;
   logic            core_run_o;
   logic            core_done = 1'b0;
   logic [15:0]     core_result = 16'd0;
   logic [PC_W-1:0] pc_o;
   logic            busy_o;
   logic            err_o;

   bitty_fetch_ctrl #(
      .PC_W    (PC_W),
      .WDOG_CYC(WDOG)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .start_i      (start),
      .stop_i       (stop),
      .imem_addr_o  (imem_addr_o),
      .imem_rd_o    (imem_rd_o),
      .imem_data_i  (imem_data),
      .imem_valid_i (imem_valid),
      .core_instr_o (core_instr_o),
      .core_run_o   (core_run_o),
      .core_done_i  (core_done),
      .core_result_i(core_result),
      .pc_o         (pc_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] mem [256];
   logic [15:0] exp_q [$];
   int          lat = 1, core_lat = 1, stop_after = 0, fetches = 0, rd_cnt = 0, core_cnt = 0;
   logic        spur_valid = 1'b0, spur_done = 1'b0;
   int          busy_cyc = 0, rd_cyc = 0, run_cnt = 0, last_busy = 0, last_rd = 0, last_runs = 0;
   logic        prev_run = 1'b0, prev_rd = 1'b0;
   logic [7:0]  prev_addr = 8'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   // Architectural interpreter: walks the program, queues issued words, totals cycle costs.
   function automatic void model_run(input int steps, input logic [15:0] result, input int L,
                                     input int D, output logic [7:0] fpc, output int busy_exp,
                                     output int rd_exp, output int issues);
      logic [7:0]  p;
      logic [15:0] ins;
      int          cond;
      bit          tk;
      p = 8'd0; busy_exp = 0; rd_exp = 0; issues = 0;
      for (int s = 0; s < steps; s++) begin
         ins = mem[p];
         rd_exp += L;
         if (ins[1:0] == 2'b10) begin
            cond = int'(ins[3:2]);
            tk = (cond == 0 && result == 16'd0) || (cond == 1 && result == 16'd1) ||
                 (cond == 2 && result == 16'd2);
            p = tk ? ins[11:4] : p + 8'd1;
            busy_exp += 1 + L;
         end else begin
            exp_q.push_back(ins);
            issues++;
            p = p + 8'd1;
            busy_exp += 2 + L + D;
         end
      end
      fpc = p;
   endfunction

   task automatic compare_cycle();
      if (core_run_o) begin
         run_cnt++;
         if (exp_q.size() == 0) check("unexpected_run", 32'd1, 32'd0);
         else check("core_instr", core_instr_o, exp_q.pop_front());
         check("run_one_cycle", prev_run, 0);
      end
      if (imem_rd_o) begin
         rd_cyc++;
         if (prev_rd) check("addr_stable", imem_addr_o, prev_addr);
      end
      if (busy_o) busy_cyc++;
      check("addr_eq_pc", imem_addr_o, pc_o);
      if (err_o) check("err_quiet", {busy_o, imem_rd_o, core_run_o}, 0);
      prev_run  = core_run_o;
      prev_rd   = imem_rd_o;
      prev_addr = imem_addr_o;
   endtask

   task automatic drive();
      if (imem_rd_o) begin
         rd_cnt++;
         if (rd_cnt >= lat) begin
            imem_valid = 1'b1;
            imem_data  = mem[imem_addr_o];
            rd_cnt     = 0;
            fetches++;
            if (fetches == stop_after) stop = 1'b1;
         end else begin
            imem_valid = 1'b0;
            imem_data  = 16'hBEEF;
         end
      end else begin
         imem_valid = 1'b0;
         rd_cnt     = 0;
      end
      imem_valid = imem_valid | spur_valid;
      core_done  = spur_done;
      if (core_run_o) core_cnt = core_lat;
      else if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) core_done = 1'b1;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      compare_cycle();
      drive();
   endtask

   task automatic run_program(input int steps, input logic [15:0] result, input int L, input int D);
      logic [7:0] fpc;
      int busy_exp, rd_exp, issues, b0, r0, n0, waited;
      exp_q.delete();
      model_run(steps, result, L, D, fpc, busy_exp, rd_exp, issues);
      lat = L; core_lat = D; core_result = result; stop_after = steps;
      fetches = 0; rd_cnt = 0; core_cnt = 0; stop = 1'b0;
      b0 = busy_cyc; r0 = rd_cyc; n0 = run_cnt;
      start = 1'b1;
      cycle();
      start = 1'b0;
      waited = 0;
      while (busy_o && waited < 2000) begin
         cycle();
         waited++;
      end
      check("prog_finished", {31'd0, busy_o}, 0);
      check("final_pc", pc_o, fpc);
      check("busy_cycles", busy_cyc - b0, busy_exp);
      check("rd_cycles", rd_cyc - r0, rd_exp);
      check("run_pulses", run_cnt - n0, issues);
      check("issues_left", exp_q.size(), 0);
      last_busy = busy_cyc - b0;
      last_rd   = rd_cyc - r0;
      last_runs = run_cnt - n0;
      stop = 1'b0;
   endtask

   initial begin
      int n;
      clear_mem();
      cycle();
      check("rst_pc", pc_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_err", err_o, 0);
      check("rst_rd", imem_rd_o, 0);
      check("rst_run", core_run_o, 0);
      check("rst_instr", core_instr_o, 0);
      rst_ni = 1'b1;
      cycle();

      mem[0] = 16'h0001; mem[1] = 16'h0005;
      run_program(2, 16'd0, 1, 3);
      check("lit_two_pc", pc_o, 8'h02);
      check("lit_two_busy", last_busy, 12);
      check("lit_two_runs", last_runs, 2);

      run_program(1, 16'd0, 1, 1);
      check("lit_min_busy", last_busy, 4);
      check("lit_min_pc", pc_o, 8'h01);

      clear_mem(); mem[0] = 16'h0142;
      run_program(1, 16'd0, 1, 1);
      check("lit_beq_taken_pc", pc_o, 8'h14);
      check("lit_branch_busy", last_busy, 2);
      check("lit_branch_runs", last_runs, 0);
      run_program(1, 16'd1, 1, 1);
      check("lit_beq_not_taken_pc", pc_o, 8'h01);

      clear_mem(); mem[0] = 16'h077A;
      run_program(1, 16'd2, 1, 1);
      check("lit_blt_taken_pc", pc_o, 8'h77);

      clear_mem();
      mem[0] = 16'h0051; mem[1] = 16'h0306; mem[8'h30] = 16'h0502;
      mem[8'h31] = 16'h060E; mem[8'h32] = 16'h1234;
      run_program(5, 16'd1, 2, 2);
      check("lit_mixed_pc", pc_o, 8'h33);
      check("lit_mixed_busy", last_busy, 21);

      spur_valid = 1'b1; spur_done = 1'b1;
      repeat (3) begin
         cycle();
         check("spur_busy", busy_o, 0);
         check("spur_rd", imem_rd_o, 0);
         check("spur_run", core_run_o, 0);
         check("spur_pc", pc_o, 8'h33);
      end
      spur_valid = 1'b0; spur_done = 1'b0;
      cycle();

      clear_mem(); mem[0] = 16'h0FF2; mem[8'hFF] = 16'h0003;
      run_program(2, 16'd0, 1, 1);
      check("lit_wrap_pc", pc_o, 8'h00);
      check("lit_wrap_busy", last_busy, 6);

      clear_mem(); mem[0] = 16'h0001; mem[1] = 16'h0005;
      run_program(2, 16'd0, 5, 1);
      check("lit_slow_busy", last_busy, 16);
      check("lit_slow_rd", last_rd, 10);
      check("lit_slow_pc", pc_o, 8'h02);

      run_program(1, 16'd0, 1, WDOG);
      check("lit_done_wins_err", err_o, 0);
      check("lit_done_wins_busy", last_busy, 4 + WDOG - 1);

      clear_mem(); mem[0] = 16'h0007;
      exp_q.delete(); exp_q.push_back(16'h0007);
      lat = 1; core_lat = 0; stop_after = 0; fetches = 0; rd_cnt = 0; core_cnt = 0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      n = 0;
      while (!core_run_o && n < 20) begin cycle(); n++; end
      check("rst_mid_run_seen", core_run_o, 1);
      #2 rst_ni = 1'b0;
      #1;
      check("rst_mid_run", core_run_o, 0);
      check("rst_mid_instr", core_instr_o, 0);
      check("rst_mid_pc", pc_o, 0);
      check("rst_mid_busy", busy_o, 0);
      check("rst_mid_rd", imem_rd_o, 0);
      check("rst_mid_err", err_o, 0);
      cycle();
      rst_ni = 1'b1;
      repeat (2) cycle();
      check("rst_mid_idle_busy", busy_o, 0);
      check("rst_mid_idle_rd", imem_rd_o, 0);

      exp_q.delete(); exp_q.push_back(16'h0007);
      start = 1'b1;
      cycle();
      start = 1'b0;
      n = 0;
      while (!core_run_o && n < 20) begin cycle(); n++; end
      check("wdog_run_seen", core_run_o, 1);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!err_o && n < 400);
      check("wdog_wait_cycles", n - 1, WDOG);
      check("wdog_err", err_o, 1);
      check("wdog_busy", busy_o, 0);
      check("wdog_pc", pc_o, 0);
      start = 1'b1;
      repeat (5) cycle();
      start = 1'b0;
      check("err_sticky", err_o, 1);
      check("err_start_ignored_busy", busy_o, 0);
      check("err_start_ignored_rd", imem_rd_o, 0);
      #2 rst_ni = 1'b0;
      #1;
      check("err_cleared_by_reset", err_o, 0);
      cycle();
      rst_ni = 1'b1;
      cycle();
      check("post_err_idle", busy_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
